fir_stream_feeder: RTL and testbench
====================================

Name: fir_stream_feeder

Overview:
- Host-side transmitter for the FIR filter's input stream.
- Accepts bytes from a simple valid/ready host write port and buffers them in a small FIFO.
- Tags each byte as sample or coefficient, then drives the FIR input interface: 8-bit data, tvalid, set_coeffs.
- Sits between the host/pin logic and the FIR core, so host writes are never lost when the FIR back-pressures.

Parameters:
- DATA_W, 8, sample/coefficient byte width.
- NUM_TAPS, 4, coefficients per coefficient-load frame (1..15).
- FIFO_DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- host_wdata  in  DATA_W  byte from host.
- host_wvalid  in  1  host byte valid.
- host_wready  out  1  feeder can accept; a byte is accepted on an edge where host_wvalid & host_wready.
- host_load_coeffs  in  1  single-cycle request; starts a coefficient frame of NUM_TAPS bytes.
- m_axis_fir_tdata  out  DATA_W  byte to FIR.
- m_axis_fir_tvalid  out  1  byte valid to FIR.
- m_axis_fir_tready  in  1  FIR accepts; tie high if the FIR has no back-pressure.
- m_set_coeffs  out  1  high with tvalid when the presented byte is a coefficient.
- coeff_busy  out  1  coefficient frame still being collected from host.
- fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy; output register not counted.
- cfg_err  out  1  sticky: load request ignored because a frame was already open.

Behaviour:
Reset
- While rst_n=0 at a rising edge: FIFO emptied, fifo_level=0.
- m_axis_fir_tvalid=0, m_axis_fir_tdata=0, m_set_coeffs=0.
- coeff_busy=0, cfg_err=0, host_wready=0 during reset; after reset host_wready=1.
- Reset mid-frame abandons the partial coefficient frame and every buffered byte.

Write side (tagging)
- Counter coeff_rem, range 0..NUM_TAPS; coeff_busy = (coeff_rem != 0).
- host_load_coeffs with coeff_rem=0: coeff_rem := NUM_TAPS.
- A byte accepted in that same cycle is the first coefficient, so coeff_rem := NUM_TAPS-1.
- host_load_coeffs with coeff_rem!=0: request ignored, cfg_err := 1 (sticky until reset).
- Each accepted byte is stored as {tag, data}; tag=1 if coeff_rem!=0 (or a new frame starts this cycle), else 0.
- Each accepted coefficient byte decrements coeff_rem.
- host_wready = FIFO not full, from registered state only; no same-cycle pass-through when full, even if a pop occurs.

FIFO
- Circular buffer, FIFO_DEPTH entries, read/write pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: level unchanged.
- Push when full is impossible by construction; pop when empty never happens.

Output register
- Loads the FIFO head when FIFO non-empty and (tvalid=0 or tready=1).
- On load: tdata := head data, m_set_coeffs := head tag, tvalid := 1, pop FIFO.
- On transfer (tvalid & tready) with FIFO empty: tvalid := 0, m_set_coeffs := 0; tdata holds its last value.
- While tvalid=1 and tready=0, tdata and m_set_coeffs are stable.
- Latency: byte accepted at edge k into an empty feeder is presented with tvalid=1 after edge k+1.
- Back-to-back throughput: one byte per cycle with tready=1.
- Byte order is strictly preserved; coefficient frames are never interleaved with samples.

Test Plan:
- Reset then idle -> all outputs 0 except host_wready=1; fifo_level=0.
- Write samples 0x11,0x22,0x33 on consecutive cycles, tready=1 -> tvalid high on 3 consecutive cycles starting one cycle after the first write; data 0x11,0x22,0x33; m_set_coeffs=0.
- host_load_coeffs together with byte 0x01, then 0x02,0x03,0x04,0x55 -> first four bytes presented with m_set_coeffs=1; 0x55 with m_set_coeffs=0; coeff_busy high from the cycle after the request until the 4th coefficient is accepted.
- tready=0, write 6 bytes (DEPTH=4) -> fifo_level reaches 4 and host_wready=0 (one more byte held in the output register); release tready -> all 5 bytes emerge in order, then the 6th is accepted.
- host_load_coeffs again after 2 of 4 coefficients -> cfg_err=1; frame still closes after 2 more bytes.
- Assert rst_n=0 mid-frame with 2 bytes buffered -> next cycle everything cleared; a following plain byte 0x7F emerges with m_set_coeffs=0.

Source files
------------

// File: rtl/fir_stream_feeder.sv
// Host-to-FIR stream feeder: buffers host bytes in a small FIFO, tags each one
// as sample or coefficient, and presents them on a registered valid/ready output.
module fir_stream_feeder #(
  parameter int DATA_W     = 8,
  parameter int NUM_TAPS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             host_wdata,
  input  logic                          host_wvalid,
  output logic                          host_wready,
  input  logic                          host_load_coeffs,
  output logic [DATA_W-1:0]             m_axis_fir_tdata,
  output logic                          m_axis_fir_tvalid,
  input  logic                          m_axis_fir_tready,
  output logic                          m_set_coeffs,
  output logic                          coeff_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cfg_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NUM_TAPS + 1);

  typedef logic [DATA_W:0] entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic                err_q, err_d;
  logic                tvalid_q, tvalid_d, set_q, set_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                full, empty, push, pop, start, tag;
  entry_t              head;

  assign full        = (level_q == LW'(FIFO_DEPTH));
  assign empty       = (level_q == '0);
  assign host_wready = rst_n & ~full;
  assign push        = host_wvalid & host_wready;
  // A load request with a frame already open is ignored; it only flags cfg_err.
  assign start       = host_load_coeffs & (rem_q == '0);
  assign tag         = start | (rem_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign pop         = ~empty & (~tvalid_q | m_axis_fir_tready);

  always_comb begin
    rem_d    = rem_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    tvalid_d = tvalid_q;
    set_d    = set_q;
    tdata_d  = tdata_q;

    // write side: coefficient frame tracking
    if (host_load_coeffs && (rem_q != '0)) err_d = 1'b1;
    if (start)
      rem_d = push ? CW'(NUM_TAPS - 1) : CW'(NUM_TAPS);
    else if (push && (rem_q != '0))
      rem_d = rem_q - CW'(1);

    // FIFO pointers and occupancy
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // output register stage
    if (pop) begin
      tdata_d  = head[DATA_W-1:0];
      set_d    = head[DATA_W];
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_axis_fir_tready) begin
      tvalid_d = 1'b0;
      set_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      set_q    <= 1'b0;
      tdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      set_q    <= set_d;
      tdata_q  <= tdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tag, host_wdata};
  end

  assign m_axis_fir_tdata  = tdata_q;
  assign m_axis_fir_tvalid = tvalid_q;
  assign m_set_coeffs      = set_q;
  assign coeff_busy        = (rem_q != '0);
  assign fifo_level        = level_q;
  assign cfg_err           = err_q;

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Bench for fir_stream_feeder: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based scoreboard.
module tb_fir_stream_feeder;

  localparam int NT = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] host_wdata;
  logic       host_wvalid, host_wready, host_load_coeffs;
  logic [7:0] tdata;
  logic       tvalid, tready, set_coeffs, coeff_busy, cfg_err;
  logic [2:0] fifo_level;

  fir_stream_feeder #(.DATA_W(8), .NUM_TAPS(NT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_load_coeffs(host_load_coeffs),
    .m_axis_fir_tdata(tdata), .m_axis_fir_tvalid(tvalid), .m_axis_fir_tready(tready),
    .m_set_coeffs(set_coeffs), .coeff_busy(coeff_busy),
    .fifo_level(fifo_level), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: ordered queue of {tag,data} bytes still owed to the FIR
  logic [8:0] q[$];
  int         rem = 0;
  bit         err = 0;
  bit         sb_en = 0;
  bit         last_acc = 0;
  int         n_xfer = 0;
  logic [8:0] last_xfer = '0;
  bit         prev_stall = 0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, score the pre-edge state, advance to next negedge.
  task automatic cycle(input logic [7:0] d, input logic v, input logic ld, input logic tr);
    logic [8:0] exp_b;
    bit acc, start;
    host_wdata = d; host_wvalid = v; host_load_coeffs = ld; tready = tr;
    #1;
    acc = host_wvalid && host_wready;
    last_acc = acc;
    if (sb_en) begin
      chk("outstanding", 32'(fifo_level) + 32'(tvalid), q.size());
      chk("coeff_busy", coeff_busy, rem != 0);
      chk("cfg_err", cfg_err, err);
      chk("wready", host_wready, rst_n && (fifo_level != 3'(DEPTH)));
      if (!tvalid) chk("set_idle", set_coeffs, 0);
      if (prev_stall) chk("stall_hold", {tvalid, set_coeffs, tdata}, {1'b1, prev_out});
      if (tvalid && tready) begin
        if (q.size() == 0) chk("xfer_unexpected", 1, 0);
        else begin
          exp_b = q.pop_front();
          chk("xfer_byte", {set_coeffs, tdata}, exp_b);
        end
        last_xfer = {set_coeffs, tdata};
        n_xfer++;
      end
      prev_stall = tvalid && !tready;
      prev_out = {set_coeffs, tdata};
      start = ld && (rem == 0);
      if (ld && rem != 0) err = 1;
      if (start) rem = NT;
      if (acc) begin
        q.push_back({rem != 0, d});
        if (rem != 0) rem--;
      end
    end
    if (!rst_n) begin
      q.delete(); rem = 0; err = 0; prev_stall = 0; sb_en = 1;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d, input logic ld, input logic tr);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      cycle(d, 1'b1, (i == 0) ? ld : 1'b0, tr);
      done = last_acc;
    end
    chk("wr_accept", done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) cycle(8'h00, 1'b0, 1'b0, 1'b1);
    chk("drained", q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       v, ld;
    logic [7:0] e_data;
    logic       e_vld, e_set, e_busy;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int xf0;
    tbl[0]  = '{8'h11, 1, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{8'h22, 1, 0, 8'h11, 1, 0, 0};
    tbl[2]  = '{8'h33, 1, 0, 8'h22, 1, 0, 0};
    tbl[3]  = '{8'h00, 0, 0, 8'h33, 1, 0, 0};
    tbl[4]  = '{8'h00, 0, 0, 8'h33, 0, 0, 0};
    tbl[5]  = '{8'h01, 1, 1, 8'h33, 0, 0, 1};
    tbl[6]  = '{8'h02, 1, 0, 8'h01, 1, 1, 1};
    tbl[7]  = '{8'h03, 1, 0, 8'h02, 1, 1, 1};
    tbl[8]  = '{8'h04, 1, 0, 8'h03, 1, 1, 0};
    tbl[9]  = '{8'h55, 1, 0, 8'h04, 1, 1, 0};
    tbl[10] = '{8'h00, 0, 0, 8'h55, 1, 0, 0};
    tbl[11] = '{8'h00, 0, 0, 8'h55, 0, 0, 0};

    rst_n = 1'b0; host_wdata = '0; host_wvalid = 0; host_load_coeffs = 0; tready = 0;
    @(negedge clk);
    cycle(8'h00, 0, 0, 0);
    cycle(8'h00, 0, 0, 0);
    chk("rst_outputs", {tvalid, tdata, set_coeffs, coeff_busy, cfg_err, fifo_level, host_wready}, '0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_wready", host_wready, 1);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].d, tbl[i].v, tbl[i].ld, 1'b1);
      chk($sformatf("vec%0d", i), {tvalid, set_coeffs, coeff_busy, host_wready, tdata},
          {tbl[i].e_vld, tbl[i].e_set, tbl[i].e_busy, 1'b1, tbl[i].e_data});
    end

    // back-pressure: fill FIFO plus output register, then release
    xf0 = n_xfer;
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("bp_level", fifo_level, 4);
    chk("bp_wready", host_wready, 0);
    chk("bp_out", {tvalid, tdata}, {1'b1, 8'hA0});
    cycle(8'hA5, 1, 0, 0);
    chk("bp_no_accept_full", last_acc, 0);
    wr(8'hA5, 1'b0, 1'b1);
    drain();
    chk("bp_count", n_xfer - xf0, 6);

    // second load request inside an open frame
    chk("err_clear", cfg_err, 0);
    wr(8'hC1, 1'b1, 1'b1);
    wr(8'hC2, 1'b0, 1'b1);
    wr(8'hC3, 1'b1, 1'b1);
    chk("err_set", {cfg_err, coeff_busy}, 2'b11);
    wr(8'hC4, 1'b0, 1'b1);
    chk("frame_closed", coeff_busy, 0);
    wr(8'h66, 1'b0, 1'b1);
    drain();
    chk("err_sticky", cfg_err, 1);
    chk("after_frame_sample", last_xfer, {1'b0, 8'h66});

    // reset mid-frame with two bytes buffered
    wr(8'hD1, 1'b1, 1'b0);
    wr(8'hD2, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(8'h00, 0, 0, 0);
    chk("midrst_clear", {tvalid, tdata, set_coeffs, coeff_busy, cfg_err, fifo_level, host_wready}, '0);
    rst_n = 1'b1;
    xf0 = n_xfer;
    wr(8'h7F, 1'b0, 1'b1);
    drain();
    chk("midrst_count", n_xfer - xf0, 1);
    chk("midrst_byte", last_xfer, {1'b0, 8'h7F});

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      cycle(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) != 0));
      rst_n = 1'b1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
